// File: rtl/athena_hiscore_save.sv
// -----------------------------------------------------------------------------
// athena_hiscore_save
//
// Snapshots the hi-score table out of the game's side RAM into an internal word
// buffer so the host can read it back over the bridge and persist it. This is
// the save-direction counterpart to the hi-score loader and sits beside it on
// the side RAM mux and the bridge read-data mux.
//
// A save_req pulse pauses the game CPU (pause_req / pause_ack). Once the CPU is
// paused, the block takes over the side RAM lines and streams SLOT_SIZE bytes
// starting at RAM_BASE into the buffer. Bridge reads that fall in the slot
// window are answered one cycle later from the buffer (big-endian packing,
// byte k in word k/4, lane 0 in bits [31:24]).
//
// Ports:
//   clk            block clock; bridge and side RAM port are synchronous to it
//   reset          synchronous, active-high
//   save_req       single-cycle pulse requesting a snapshot
//   pause_req      request CPU pause
//   pause_ack      CPU is paused and RAM lines may be driven
//   ram_override   block owns the side RAM lines
//   ram_addr       side RAM address (11 bits, wraps modulo 2048)
//   ram_ncs        active-low chip select, low for each address issued
//   ram_nwe        active-low write enable, always 1 (read only)
//   ram_rd_data    side RAM read data, valid RAM_RD_LATENCY cycles after address
//   bridge_rd      bridge read strobe
//   bridge_addr    bridge byte address
//   bridge_rd_data read data, one cycle after bridge_rd
//   bridge_rd_hit  bridge_rd_data belongs to this block's window
//   snapshot_valid buffer holds a complete snapshot
//   busy           copy in progress
// -----------------------------------------------------------------------------
module athena_hiscore_save #(
  parameter logic [10:0] RAM_BASE       = 11'h650,
  parameter logic [15:0] SLOT_SIZE      = 16'h72,
  parameter logic [31:0] SLOT_ADDR      = 32'h1000_0000,
  parameter int          RAM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_req,
  output logic        pause_req,
  input  logic        pause_ack,
  output logic        ram_override,
  output logic [10:0] ram_addr,
  output logic        ram_ncs,
  output logic        ram_nwe,
  input  logic [7:0]  ram_rd_data,
  input  logic        bridge_rd,
  input  logic [31:0] bridge_addr,
  output logic [31:0] bridge_rd_data,
  output logic        bridge_rd_hit,
  output logic        snapshot_valid,
  output logic        busy
);

  localparam int          NUM_WORDS = (int'(SLOT_SIZE) + 3) / 4;
  localparam int          WIDX      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [8:0]  LAST      = 9'(SLOT_SIZE - 16'd1);
  localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PAUSE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                state;
  logic [8:0]                issue_cnt;   // next byte offset to address
  logic [8:0]                cap_cnt;     // next byte offset to capture
  logic [RAM_RD_LATENCY-1:0] vpipe;       // tracks issued addresses through RAM latency
  logic                      issuing;
  logic                      capture;
  logic [31:0]               buf_mem [NUM_WORDS];

  // Addresses go out back to back; the valid pipe tells us when each byte's
  // data arrives, so capture order simply follows issue order.
  assign issuing = (state == S_READ) && (issue_cnt <= LAST);
  assign capture = vpipe[RAM_RD_LATENCY-1];

  assign pause_req    = (state == S_PAUSE) || (state == S_READ);
  assign busy         = (state == S_PAUSE) || (state == S_READ);
  assign ram_override = (state == S_READ);
  assign ram_ncs      = !issuing;
  assign ram_nwe      = 1'b1;
  assign ram_addr     = issuing ? (RAM_BASE + {3'b000, issue_cnt[7:0]}) : 11'h000;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      issue_cnt      <= '0;
      cap_cnt        <= '0;
      vpipe          <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      vpipe[0] <= issuing;
      for (int i = 1; i < RAM_RD_LATENCY; i++) vpipe[i] <= vpipe[i-1];

      case (state)
        S_IDLE: begin
          if (save_req) begin
            state          <= S_PAUSE;
            snapshot_valid <= 1'b0;
            issue_cnt      <= '0;
            cap_cnt        <= '0;
          end
        end
        S_PAUSE: begin
          if (pause_ack) state <= S_READ;
        end
        S_READ: begin
          // pause_ack is deliberately ignored here: once started, the copy
          // runs to completion.
          if (issuing) issue_cnt <= issue_cnt + 9'd1;
          if (capture) begin
            cap_cnt <= cap_cnt + 9'd1;
            if (cap_cnt == LAST) state <= S_DONE;
          end
        end
        default: begin  // S_DONE
          snapshot_valid <= 1'b1;
          state          <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the buffer has no reset; snapshot_valid guards every read of it, so
  // its contents are irrelevant until a full copy has landed.
  logic [WIDX-1:0] wr_idx;
  assign wr_idx = cap_cnt[WIDX+1:2];

  always_ff @(posedge clk) begin
    if (capture) begin
      // Lane 0 rewrites the whole word so the unused lanes of a partial last
      // word read back as zero.
      case (cap_cnt[1:0])
        2'd0:    buf_mem[wr_idx]        <= {ram_rd_data, 24'h000000};
        2'd1:    buf_mem[wr_idx][23:16] <= ram_rd_data;
        2'd2:    buf_mem[wr_idx][15:8]  <= ram_rd_data;
        default: buf_mem[wr_idx][7:0]   <= ram_rd_data;
      endcase
    end
  end

  // Bridge window decode. The offset is only meaningful when the address is at
  // or above SLOT_ADDR, which also keeps the compare free of overflow.
  logic [31:0]     offset;
  logic            win_hit;
  logic [WIDX-1:0] rd_idx;

  assign offset  = bridge_addr - SLOT_ADDR;
  assign win_hit = bridge_rd && (bridge_addr >= SLOT_ADDR) && (offset < WIN_BYTES);
  assign rd_idx  = offset[WIDX+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      bridge_rd_hit  <= 1'b0;
      bridge_rd_data <= '0;
    end else begin
      bridge_rd_hit  <= win_hit;
      bridge_rd_data <= (win_hit && snapshot_valid && !busy) ? buf_mem[rd_idx] : 32'h0;
    end
  end

endmodule
